pulse_delay_bank: RTL and testbench

//  Multi-channel successor to the single-button delayed-pulse counter for the microwave keypad/encoder path.

---
 rtl/pulse_delay_bank_if.sv | 28 ++
 rtl/pulse_delay_bank.sv | 127 ++++++++++++
 tb/tb_pulse_delay_bank.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/pulse_delay_bank_if.sv
// Signal bundle between the keypad front end and the pulse delay bank.
// The master drives the raw button levels; the bank returns pulses, busy flags and the encoder result.
interface pulse_delay_bank_if #(
  parameter int unsigned CH    = 4,
  parameter int unsigned CODEW = 2
);
  logic [CH-1:0]    push;
  logic [CH-1:0]    out;
  logic [CH-1:0]    busy;
  logic             out_valid;
  logic [CODEW-1:0] out_code;

  modport master (
    output push,
    input  out,
    input  busy,
    input  out_valid,
    input  out_code
  );

  modport slave (
    input  push,
    output out,
    output busy,
    output out_valid,
    output out_code
  );
endinterface

// File: rtl/pulse_delay_bank.sv
// Bank of independent edge-triggered delayed-pulse channels with a lowest-index priority encoder.
// Each channel: edge -> DELAY cycles -> WIDTH-cycle pulse -> hold-off until TOTAL cycles have elapsed.
module pulse_delay_bank #(
  parameter int unsigned CH        = 4,
  parameter int unsigned DELAY     = 8,
  parameter int unsigned WIDTH     = 2,
  parameter int unsigned TOTAL     = 14,
  parameter int unsigned RETRIGGER = 0,
  parameter int unsigned CW        = 4,
  parameter int unsigned CODEW     = 2
) (
  input  logic              clk,
  input  logic              clr,
  pulse_delay_bank_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StWait, StPulse, StHold} state_e;

  localparam logic [CW-1:0] CntOne    = CW'(1);
  localparam logic [CW-1:0] DelayC    = CW'(DELAY);
  localparam logic [CW-1:0] PulseEndC = CW'(DELAY + WIDTH - 1);
  localparam logic [CW-1:0] TotalC    = CW'(TOTAL);
  localparam state_e        StFirst   = (DELAY == 1) ? StPulse : StWait;

  if (CH < 1) begin : g_chk_ch
    $error("pulse_delay_bank: CH must be >= 1");
  end
  if (DELAY < 1 || WIDTH < 1) begin : g_chk_dw
    $error("pulse_delay_bank: DELAY and WIDTH must be >= 1");
  end
  if (DELAY + WIDTH - 1 > TOTAL || TOTAL > (2 ** CW) - 1) begin : g_chk_total
    $error("pulse_delay_bank: need DELAY+WIDTH-1 <= TOTAL <= 2^CW-1");
  end
  if (CODEW < 1 || CODEW < $clog2(CH)) begin : g_chk_codew
    $error("pulse_delay_bank: CODEW too narrow for CH");
  end

  logic [CH-1:0]    push_q;
  logic [CH-1:0]    edge_det;
  logic [CH-1:0]    out_vec;
  logic [CH-1:0]    busy_vec;
  logic [CODEW-1:0] code;

  // Reset loads all-ones so a button already held when clr drops never fires.
  always_ff @(posedge clk) begin
    if (clr) begin
      push_q <= '1;
    end else begin
      push_q <= bus.push;
    end
  end

  assign edge_det = bus.push & ~push_q;

  for (genvar g = 0; g < CH; g++) begin : g_ch
    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          out_q, out_d;
    logic          busy_q, busy_d;
    logic          fin;
    logic          start;

    // Accept beats finish, so an edge on the last busy cycle starts a fresh timeline.
    assign fin   = (state_q != StIdle) && (cnt_q == TotalC);
    assign start = edge_det[g] && ((state_q == StIdle) || fin || (RETRIGGER != 0));

    always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      out_d   = 1'b0;
      if (start) begin
        cnt_d   = CntOne;
        state_d = StFirst;
      end else if (state_q == StIdle) begin
        cnt_d = '0;
      end else if (fin) begin
        state_d = StIdle;
        cnt_d   = '0;
        out_d   = (state_q == StPulse);
      end else begin
        cnt_d = cnt_q + CntOne;
        out_d = (state_q == StPulse);
        if (cnt_d < DelayC) begin
          state_d = StWait;
        end else if (cnt_d <= PulseEndC) begin
          state_d = StPulse;
        end else begin
          state_d = StHold;
        end
      end
      busy_d = (state_d != StIdle);
    end

    always_ff @(posedge clk) begin
      if (clr) begin
        state_q <= StIdle;
        cnt_q   <= '0;
        out_q   <= 1'b0;
        busy_q  <= 1'b0;
      end else begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
        out_q   <= out_d;
        busy_q  <= busy_d;
      end
    end

    assign out_vec[g]  = out_q;
    assign busy_vec[g] = busy_q;
  end

  // Scan from the top so the lowest-numbered active channel is written last.
  always_comb begin
    code = '0;
    for (int i = CH - 1; i >= 0; i--) begin
      if (out_vec[i]) begin
        code = CODEW'(i);
      end
    end
  end

  assign bus.out       = out_vec;
  assign bus.busy      = busy_vec;
  assign bus.out_valid = |out_vec;
  assign bus.out_code  = code;

endmodule

// File: tb/tb_pulse_delay_bank.sv
// Directed and random stimulus for two pulse_delay_bank instances (RETRIGGER 0 and 1) fed the
// same buttons, checked against a timeline model built from each channel's accepted edge time.
module tb_pulse_delay_bank;
  localparam int CH    = 4;
  localparam int DELAY = 8;
  localparam int WIDTH = 2;
  localparam int TOTAL = 14;
  localparam int CW    = 4;
  localparam int CODEW = 2;
  localparam int NONE  = -1000;

  logic clk = 1'b0;
  logic clr = 1'b1;
  always #5 clk = ~clk;

  pulse_delay_bank_if #(.CH(CH), .CODEW(CODEW)) bus0 ();
  pulse_delay_bank_if #(.CH(CH), .CODEW(CODEW)) bus1 ();

  pulse_delay_bank #(
    .CH(CH), .DELAY(DELAY), .WIDTH(WIDTH), .TOTAL(TOTAL), .RETRIGGER(0), .CW(CW), .CODEW(CODEW)
  ) dut0 (
    .clk (clk),
    .clr (clr),
    .bus (bus0.slave)
  );

  pulse_delay_bank #(
    .CH(CH), .DELAY(DELAY), .WIDTH(WIDTH), .TOTAL(TOTAL), .RETRIGGER(1), .CW(CW), .CODEW(CODEW)
  ) dut1 (
    .clk (clk),
    .clr (clr),
    .bus (bus1.slave)
  );

  int            errors = 0;
  int            checks = 0;
  int            cyc    = 0;
  int            t0[2][CH];
  logic [CH-1:0] prev;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // One clock: drive inputs at negedge, advance the model at posedge, compare 1 time unit later.
  task automatic step(input logic [CH-1:0] pv, input logic cv);
    logic [CH-1:0]    edg;
    logic [CH-1:0]    eo;
    logic [CH-1:0]    eb;
    logic [CODEW-1:0] ec;
    int               d;
    @(negedge clk);
    bus0.push = pv;
    bus1.push = pv;
    clr       = cv;
    @(posedge clk);
    cyc++;
    if (cv) begin
      prev = '1;
      for (int r = 0; r < 2; r++) for (int i = 0; i < CH; i++) t0[r][i] = NONE;
    end else begin
      edg  = pv & ~prev;
      prev = pv;
      for (int r = 0; r < 2; r++) begin
        for (int i = 0; i < CH; i++) begin
          if (edg[i] && (r == 1 || cyc - t0[r][i] >= TOTAL)) t0[r][i] = cyc;
        end
      end
    end
    #1;
    for (int r = 0; r < 2; r++) begin
      eo = '0;
      eb = '0;
      ec = '0;
      for (int i = 0; i < CH; i++) begin
        d     = cyc - t0[r][i];
        eo[i] = (d >= DELAY) && (d <= DELAY + WIDTH - 1);
        eb[i] = (d >= 0) && (d <= TOTAL - 1);
      end
      for (int i = CH - 1; i >= 0; i--) if (eo[i]) ec = CODEW'(i);
      if (r == 0) begin
        check("r0_out", 32'(bus0.out), 32'(eo));
        check("r0_busy", 32'(bus0.busy), 32'(eb));
        check("r0_valid", 32'(bus0.out_valid), 32'(|eo));
        check("r0_code", 32'(bus0.out_code), 32'(ec));
      end else begin
        check("r1_out", 32'(bus1.out), 32'(eo));
        check("r1_busy", 32'(bus1.busy), 32'(eb));
        check("r1_valid", 32'(bus1.out_valid), 32'(|eo));
        check("r1_code", 32'(bus1.out_code), 32'(ec));
      end
    end
  endtask

  initial begin
    logic [CH-1:0] pv;
    bus0.push = '0;
    bus1.push = '0;
    prev      = '1;
    for (int r = 0; r < 2; r++) for (int i = 0; i < CH; i++) t0[r][i] = NONE;

    // Reset with buttons released.
    step(4'b0000, 1'b1);
    step(4'b0000, 1'b1);
    check("reset_out", 32'(bus0.out), 32'd0);
    check("reset_busy", 32'(bus1.busy), 32'd0);
    step(4'b0000, 1'b0);

    // Held button on ch0: one pulse exactly DELAY cycles after the edge, WIDTH long.
    step(4'b0001, 1'b0);
    for (int j = 1; j < DELAY; j++) step(4'b0001, 1'b0);
    check("held_before", 32'(bus0.out[0]), 32'd0);
    step(4'b0001, 1'b0);
    check("held_first", 32'(bus0.out[0]), 32'd1);
    step(4'b0001, 1'b0);
    check("held_second", 32'(bus0.out[0]), 32'd1);
    step(4'b0001, 1'b0);
    check("held_after", 32'(bus0.out[0]), 32'd0);
    for (int j = 0; j < 20; j++) step(4'b0001, 1'b0);
    step(4'b0000, 1'b0);

    // ch1 pulsed at offsets 0, 4 and 7: dropped on RETRIGGER=0, restarts on RETRIGGER=1.
    for (int j = 0; j < 30; j++) begin
      step((j == 0 || j == 4 || j == 7) ? 4'b0010 : 4'b0000, 1'b0);
    end

    // Simultaneous edges on ch2 and ch3: encoder reports the lower index.
    step(4'b1100, 1'b0);
    for (int j = 0; j < DELAY; j++) step(4'b1100, 1'b0);
    check("enc_code", 32'(bus0.out_code), 32'd2);
    check("enc_valid", 32'(bus0.out_valid), 32'd1);
    for (int j = 0; j < 16; j++) step(4'b0000, 1'b0);

    // ch0 held through reset release, then clr lands mid-WAIT on ch1.
    step(4'b0001, 1'b1);
    step(4'b0001, 1'b1);
    step(4'b0001, 1'b0);
    step(4'b0011, 1'b0);
    for (int j = 0; j < 4; j++) step(4'b0011, 1'b0);
    step(4'b0011, 1'b1);
    check("clr_mid_busy", 32'(bus0.busy), 32'd0);
    for (int j = 0; j < 20; j++) step(4'b0011, 1'b0);

    // Random button activity with occasional resets.
    pv = '0;
    for (int n = 0; n < 600; n++) begin
      for (int i = 0; i < CH; i++) begin
        if ($urandom_range(4) == 0) pv[i] = ~pv[i];
      end
      step(pv, ($urandom_range(80) == 0) ? 1'b1 : 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
